fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the next-generation core. Drives
//  the synchronous instruction memory, buffers fetched words with their PCs in a
//  prefetch queue and hands them to decode via valid/ready. Adds stall, halt and
//  branch-redirect flush, which the single-cycle datapath's PC register lacks.
// PARAMETERS
//  ADDR_W    16   PC / instruction-memory address width (word addressed)
//  INST_W    32   instruction width
//  DEPTH     4    prefetch queue entries; power of 2, >= 2
//  RESET_PC  0    first fetch address after reset
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  reset        in   1       synchronous, active-high
//  halt         in   1       stop issuing new fetches (queue still drains)
//  redirect     in   1       branch/jump taken: flush and refetch
//  redirect_pc  in   ADDR_W  new fetch address when redirect=1
//  imem_req     out  1       fetch issued this cycle
//  imem_addr    out  ADDR_W  fetch address; data returns next cycle
//  imem_data    in   INST_W  read data for the request of the previous cycle
//  inst_valid   out  1       inst_out/inst_pc hold a valid entry
//  inst_ready   in   1       decode accepts the entry this cycle
//  inst_out     out  INST_W  head-of-queue instruction
//  inst_pc      out  ADDR_W  PC of inst_out
//  fetch_pc     out  ADDR_W  next address to be fetched
//  occupancy    out  log2(DEPTH)+1  entries currently queued
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC; queue empty; imem_req=0, inst_valid=0,
//    inst_out=0, inst_pc=0, occupancy=0; in-flight flag cleared; state=RUN.
//    Reset mid-operation discards queue and any in-flight response.
//  - FSM: RUN -> HALTED when halt=1; HALTED -> RUN when halt=0; any state ->
//    RUN on reset. Redirect is honoured in both states (updates fetch_pc only).
//  - Issue (registered, RUN only): imem_req=1, imem_addr=fetch_pc when
//    occupancy + inflight - pop < DEPTH, no redirect this cycle; then
//    fetch_pc <= fetch_pc+1, wrapping 2^ADDR_W-1 -> 0 (mod arithmetic).
//  - Response: one cycle after imem_req, {imem_data, issued pc} pushed to queue
//    unless flushed. Queue never overflows: issue check counts in-flight word.
//  - Latency: first inst_valid two cycles after reset deasserts (req cycle 0,
//    data cycle 1, visible cycle 2). No bypass from imem_data to inst_out.
//  - Pop: inst_valid & inst_ready removes head. Simultaneous push and pop keep
//    occupancy unchanged, also at full and at one entry.
//  - Redirect (priority over push, pop and issue): queue emptied, in-flight
//    response dropped (epoch bit toggled, tagged response ignored),
//    fetch_pc <= redirect_pc; inst_valid=0 next cycle; fetching resumes at
//    redirect_pc the following cycle (if RUN). Redirect with inst_ready=1 does
//    not count as a consumed instruction.
//  - Halt: no new imem_req from the cycle after halt rises; an already issued
//    request still completes and is queued; entries drain via inst_ready.
//  - Empty: inst_valid=0, inst_out/inst_pc hold last value (don't care to decode).
// STRUCTURE
//  - Shared package cpu_pkg: ADDR_W/INST_W defaults, fetch FSM state enum
//    (RUN, HALTED), fetch entry struct {inst, pc}.
//  - One sub-module: fetch_fifo (DEPTH x {INST_W+ADDR_W}, push/pop/flush,
//    occupancy); issue/epoch/FSM logic stays in fetch_unit.
// TESTING
//  - Reset, imem returns addr as data, inst_ready=1 -> inst_pc 0,1,2,3...
//    from cycle 2, one per cycle, occupancy<=1.
//  - inst_ready=0 for 10 cycles, DEPTH=4 -> imem_req stops with occupancy=4,
//    no entry lost; release -> PCs continue contiguous.
//  - redirect=1, redirect_pc=0x0040 with full queue and request in flight ->
//    inst_valid=0 next cycle, next inst_pc=0x0040, stale word never seen.
//  - halt=1 at fetch_pc=5 -> at most one more fetch (pc 5); queue drains;
//    halt=0 -> fetching resumes at following pc, no gap or repeat.
//  - RESET_PC=0xFFFE, ADDR_W=16 -> inst_pc 0xFFFE,0xFFFF,0x0000 (wrap).
//  - reset asserted mid-stream with occupancy=3 -> all outputs reset values
//    next cycle; restart at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: default widths, fetch FSM states and the queued fetch entry.
package cpu_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_INST_W = 32;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} fetch_state_e;

  typedef struct packed {
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of W bits, flush has priority over push/pop.
module fetch_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // leave rd_ptr alone so the head output keeps its last value
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues imem reads, queues {inst, pc}, hands to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter int              INST_W   = DEF_INST_W,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     halt,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INST_W-1:0]        imem_data,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [INST_W-1:0]        inst_out,
  output logic [ADDR_W-1:0]        inst_pc,
  output logic [ADDR_W-1:0]        fetch_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state, state_nxt;
  logic              inflight, inflight_epoch, epoch;
  logic [ADDR_W-1:0] inflight_pc;
  logic              push, pop;
  logic [CW:0]       demand;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt)  state_nxt = HALTED;
      HALTED:  if (!halt) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Issue only if the queue can absorb this word plus the one already in flight.
  always_comb begin
    pop      = inst_valid & inst_ready & ~redirect;
    push     = inflight & (inflight_epoch == epoch) & ~redirect;
    demand   = (CW+1)'(occupancy) + (CW+1)'(inflight) - (CW+1)'(pop);
    imem_req = ~reset & (state == RUN) & ~redirect & (demand < (CW+1)'(DEPTH));
  end

  assign imem_addr  = fetch_pc;
  assign inst_valid = (occupancy != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc       <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc    <= fetch_pc;
        inflight_epoch <= epoch;
      end
      if (redirect) begin
        epoch    <= ~epoch;
        fetch_pc <= redirect_pc;
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
    end
  end

  fetch_fifo #(.W(INST_W + ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({imem_data, inflight_pc}),
    .rdata ({inst_out, inst_pc}),
    .count (occupancy)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model compared every cycle plus directed literal checks.
module tb_fetch_unit;
  import cpu_pkg::*;
  localparam int AW = 16, IW = 32, DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, halt = 1'b0, redirect = 1'b0, inst_ready = 1'b0;
  logic [AW-1:0] redirect_pc = '0;

  logic          imem_req, inst_valid;
  logic [AW-1:0] imem_addr, inst_pc, fetch_pc;
  logic [IW-1:0] imem_data = '0, inst_out;
  logic [2:0]    occupancy;

  logic          w_req, w_valid;
  logic [AW-1:0] w_addr, w_inst_pc, w_fetch_pc;
  logic [IW-1:0] w_data = '0, w_inst_out;
  logic [2:0]    w_occ;

  fetch_unit #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .reset(reset), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .fetch_pc(fetch_pc), .occupancy(occupancy));

  fetch_unit #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .reset(reset), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_data(w_data),
    .inst_valid(w_valid), .inst_ready(inst_ready), .inst_out(w_inst_out), .inst_pc(w_inst_pc),
    .fetch_pc(w_fetch_pc), .occupancy(w_occ));

  function automatic logic [IW-1:0] mfn(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  // synchronous instruction memories
  always @(posedge clk) begin
    if (imem_req) imem_data <= mfn(imem_addr);
    if (w_req)    w_data    <= mfn(w_addr);
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // reference model: queue of entries, one pending response, halted flag, next pc
  fetch_entry_t  mq[$];
  bit            m_pend, m_halted, m_v, m_p, m_req;
  logic [AW-1:0] m_pend_pc, m_fpc;
  int            m_n;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        chk("req_in_reset", {63'd0, imem_req}, 64'd0);
        mq.delete();
        m_pend = 0; m_halted = 0; m_fpc = 16'h0000;
      end else begin
        m_n = mq.size();
        m_v = (m_n > 0);
        chk("valid", {63'd0, inst_valid}, {63'd0, m_v});
        chk("occupancy", {61'd0, occupancy}, 64'(m_n));
        chk("fetch_pc", {48'd0, fetch_pc}, {48'd0, m_fpc});
        if (m_v) begin
          chk("inst_out", {32'd0, inst_out}, {32'd0, mq[0].inst});
          chk("inst_pc", {48'd0, inst_pc}, {48'd0, mq[0].pc});
        end
        m_p   = m_v && inst_ready;
        m_req = !m_halted && !redirect && (m_n + int'(m_pend) - int'(m_p) < DEPTH);
        chk("imem_req", {63'd0, imem_req}, {63'd0, m_req});
        if (m_req) chk("imem_addr", {48'd0, imem_addr}, {48'd0, m_fpc});
        if (redirect) begin
          mq.delete();
          m_pend = 0;
          m_fpc  = redirect_pc;
        end else begin
          if (m_p) void'(mq.pop_front());
          if (m_pend) mq.push_back('{inst: mfn(m_pend_pc), pc: m_pend_pc});
          m_pend = m_req;
          if (m_req) begin
            m_pend_pc = m_fpc;
            m_fpc     = m_fpc + 16'd1;
          end
        end
        m_halted = halt;
      end
    end
  end

  task automatic cyc(input bit rst, input bit h, input bit r, input logic [AW-1:0] rpc, input bit rdy);
    @(negedge clk);
    reset = rst; halt = h; redirect = r; redirect_pc = rpc; inst_ready = rdy;
  endtask

  bit hit;

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    // streaming from reset, decode always ready
    cyc(0, 0, 0, 0, 1); #3;
    chk("rst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_occ", {61'd0, occupancy}, 64'd0);
    chk("rst_inst_out", {32'd0, inst_out}, 64'd0);
    chk("rst_inst_pc", {48'd0, inst_pc}, 64'd0);
    chk("rst_fetch_pc", {48'd0, fetch_pc}, 64'd0);
    chk("cyc0_req", {63'd0, imem_req}, 64'd1);
    cyc(0, 0, 0, 0, 1); #3;
    chk("cyc1_valid", {63'd0, inst_valid}, 64'd0);
    cyc(0, 0, 0, 0, 1); #3;
    chk("cyc2_pc", {48'd0, inst_pc}, 64'h0000);
    chk("wrap_pc0", {48'd0, w_inst_pc}, 64'hFFFE);
    cyc(0, 0, 0, 0, 1); #3;
    chk("cyc3_pc", {48'd0, inst_pc}, 64'h0001);
    chk("wrap_pc1", {48'd0, w_inst_pc}, 64'hFFFF);
    cyc(0, 0, 0, 0, 1); #3;
    chk("cyc4_pc", {48'd0, inst_pc}, 64'h0002);
    chk("wrap_pc2", {48'd0, w_inst_pc}, 64'h0000);
    chk("wrap_valid", {63'd0, w_valid}, 64'd1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1);

    // backpressure fills the queue
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
    #3;
    chk("full_occ", {61'd0, occupancy}, 64'd4);
    chk("full_noreq", {63'd0, imem_req}, 64'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

    // redirect with full queue and a request in flight
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0); #3;
    chk("inflight_occ", {61'd0, occupancy}, 64'd3);
    cyc(0, 0, 1, 16'h0040, 1);
    cyc(0, 0, 0, 0, 1); #3;
    chk("redir_valid", {63'd0, inst_valid}, 64'd0);
    chk("redir_req", {63'd0, imem_req}, 64'd1);
    chk("redir_addr", {48'd0, imem_addr}, 64'h0040);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1); #3;
    chk("redir_pc", {48'd0, inst_pc}, 64'h0040);
    chk("redir_inst", {32'd0, inst_out}, 64'hFFBF0040);

    // halt at fetch_pc 5
    cyc(0, 0, 1, 16'h0003, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0); #3;
    chk("halt_fpc", {48'd0, fetch_pc}, 64'h0005);
    chk("halt_last_req", {63'd0, imem_req}, 64'd1);
    cyc(0, 1, 0, 0, 0); #3;
    chk("halted_noreq", {63'd0, imem_req}, 64'd0);
    chk("halted_fpc", {48'd0, fetch_pc}, 64'h0006);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    chk("halted_occ", {61'd0, occupancy}, 64'd3);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1);
    #3;
    chk("drained_occ", {61'd0, occupancy}, 64'd0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1); #3;
    chk("resume_req", {63'd0, imem_req}, 64'd1);
    chk("resume_addr", {48'd0, imem_addr}, 64'h0006);

    // reset mid-stream with three entries queued
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc(0, 0, 0, 0, 0); #3;
      if (occupancy == 3'd3) hit = 1;
    end
    chk("reach_occ3", {63'd0, hit}, 64'd1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1); #3;
    chk("mrst_valid", {63'd0, inst_valid}, 64'd0);
    chk("mrst_occ", {61'd0, occupancy}, 64'd0);
    chk("mrst_inst_out", {32'd0, inst_out}, 64'd0);
    chk("mrst_inst_pc", {48'd0, inst_pc}, 64'd0);
    chk("mrst_fetch_pc", {48'd0, fetch_pc}, 64'd0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1); #3;
    chk("mrst_first_pc", {48'd0, inst_pc}, 64'h0000);
    chk("mrst_first_valid", {63'd0, inst_valid}, 64'd1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
